fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module : fifo_wr_arbiter_if
// Brief  : Producer/FIFO write-port bundle shared with the arbiter.
// Rev    : 1.0
// =====================================================================
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            done;
    logic [FIFO_WIDTH-1:0]       fifo_data_in;
    logic                        fifo_wr_en;
    logic                        fifo_full;
    logic                        fifo_wr_ack;
    logic                        fifo_overflow;
    logic                        busy;
    logic [CNT_WIDTH-1:0]        retry_cnt;

    // Arbiter side
    modport slave (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output gnt, done, fifo_data_in, fifo_wr_en, busy, retry_cnt
    );

    // Producers plus FIFO side
    modport master (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  gnt, done, fifo_data_in, fifo_wr_en, busy, retry_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// =====================================================================
// Module : fifo_wr_arbiter
// Brief  : Round-robin arbiter sharing one sync-FIFO write port.
// Rev    : 1.0
// =====================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int                  c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [N_REQ-1:0]       gnt_q,    gnt_d;
    logic [N_REQ-1:0]       done_q,   done_d;
    logic [FIFO_WIDTH-1:0]  data_q,   data_d;
    logic                   wr_en_q,  wr_en_d;
    logic                   busy_q,   busy_d;
    logic [CNT_WIDTH-1:0]   retry_q,  retry_d;
    logic [c_IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [c_IDX_W-1:0]     owner_q,  owner_d;

    logic [N_REQ-1:0]       w_elig;
    logic                   w_win_found;
    logic [c_IDX_W-1:0]     w_win_idx;
    logic [CNT_WIDTH-1:0]   w_retry_inc;
    logic [FIFO_WIDTH-1:0]  w_slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_slice[g] = bus.req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // The requester whose done is pulsing has already been served this round.
    assign w_elig      = bus.req & ~done_q;
    assign w_retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

    always_comb begin : p_rr_search
        int j;
        j           = 0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr_q) + k) % N_REQ;
            if (!w_win_found && w_elig[c_IDX_W'(j)]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_IDX_W'(j);
            end
        end
    end

    always_comb begin : p_next
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        data_d   = data_q;
        wr_en_d  = 1'b0;
        busy_d   = busy_q;
        retry_d  = retry_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            S_IDLE: begin
                if (w_win_found && !bus.fifo_full) begin
                    state_d            = S_WRITE;
                    gnt_d              = '0;
                    gnt_d[w_win_idx]   = 1'b1;
                    data_d             = w_slice[w_win_idx];
                    owner_d            = w_win_idx;
                    busy_d             = 1'b1;
                end
            end
            S_WRITE: begin
                wr_en_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // While the strobe is still on the port the FIFO's flags are not yet valid.
                if (!wr_en_q) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    if (bus.fifo_wr_ack) begin
                        done_d[owner_q] = 1'b1;
                        rr_ptr_d        = (owner_q == c_LAST) ? '0 : owner_q + 1'b1;
                    end else if (bus.fifo_overflow) begin
                        retry_d = w_retry_inc;
                    end else begin
                        retry_d = w_retry_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            retry_q  <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            retry_q  <= retry_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.fifo_data_in = data_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.busy         = busy_q;
    assign bus.retry_cnt    = retry_q;

endmodule
`default_nettype wire
